// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue
//   Instruction fetch unit: keeps up to MAXOUT in-order reads in flight and
//   buffers returned words with their PCs in a DEPTH-entry queue. A branch
//   redirect flushes the queue and silently drops every response that was
//   still in flight when the redirect was taken.
//
//   Optional feature macro: FETCH_BYPASS_EN
//     When defined, a word that returns while the queue is empty, with nothing
//     to discard and no redirect, is presented to decode in the same cycle. If
//     decode takes it, the word never enters the queue.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   ins_rd_addr/req   fetch request (addr valid while req=1)
//   ins_rd_ack        request accepted (req&ack = issue)
//   ins_rd_data/rdy   in-order read response
//   de_ir/de_pc       queue head word and its address
//   de_valid/ready    head valid / decode consumes head
//   br_valid/br_tgt   redirect request and target
module cpu_fetch_queue #(
   parameter int AWIDTH   = 16,
   parameter int DWIDTH   = 16,
   parameter int DEPTH    = 4,
   parameter int MAXOUT   = 2,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [AWIDTH-1:0] ins_rd_addr,
   output logic              ins_rd_req,
   input  logic              ins_rd_ack,
   input  logic [DWIDTH-1:0] ins_rd_data,
   input  logic              ins_rd_rdy,
   output logic [DWIDTH-1:0] de_ir,
   output logic [AWIDTH-1:0] de_pc,
   output logic              de_valid,
   input  logic              de_ready,
   input  logic              br_valid,
   input  logic [AWIDTH-1:0] br_tgt
);

   localparam int PW = $clog2(DEPTH);
   localparam int IW = $clog2(MAXOUT + 1);
   localparam int CW = PW + IW + 2;

   logic [AWIDTH-1:0] fetch_pc, resp_pc;
   logic [PW:0]       wr_ptr, rd_ptr, count;
   logic [IW-1:0]     inflight, discard;
   logic [CW-1:0]     credit_used;

   logic [DWIDTH-1:0] mem_ir [DEPTH];
   logic [AWIDTH-1:0] mem_pc [DEPTH];
   logic [DWIDTH-1:0] hold_ir;
   logic [AWIDTH-1:0] hold_pc;

   logic q_empty, issue, rsp_live, rsp_keep, byp, byp_take, push, pop;

   // Pointers carry a wrap bit, so the difference is the occupancy 0..DEPTH.
   assign count   = wr_ptr - rd_ptr;
   assign q_empty = (count == '0);

   // Every live read (in flight and not being discarded) owns a queue slot,
   // so a response can always be pushed without checking for full.
   assign credit_used = CW'(count) + CW'(inflight) - CW'(discard);

   assign ins_rd_addr = fetch_pc;
   assign ins_rd_req  = ~reset & ~br_valid & (inflight < IW'(MAXOUT)) &
                        (credit_used < CW'(DEPTH));
   assign issue       = ins_rd_req & ins_rd_ack;

   // A response with nothing in flight is illegal; it is ignored here.
   assign rsp_live = ins_rd_rdy & (inflight != '0);
   assign rsp_keep = rsp_live & (discard == '0);

`ifdef FETCH_BYPASS_EN
   assign byp      = ~reset & q_empty & (discard == '0) & ~br_valid & rsp_live;
   assign de_valid = ~q_empty | byp;
   assign de_ir    = ~q_empty ? mem_ir[rd_ptr[PW-1:0]] : (byp ? ins_rd_data : hold_ir);
   assign de_pc    = ~q_empty ? mem_pc[rd_ptr[PW-1:0]] : (byp ? resp_pc     : hold_pc);
`else
   assign byp      = 1'b0;
   assign de_valid = ~q_empty;
   assign de_ir    = ~q_empty ? mem_ir[rd_ptr[PW-1:0]] : hold_ir;
   assign de_pc    = ~q_empty ? mem_pc[rd_ptr[PW-1:0]] : hold_pc;
`endif

   // A bypassed word taken by decode is consumed without occupying a slot.
   assign byp_take = byp & de_ready;
   assign push     = rsp_keep & ~byp_take & ~br_valid;
   assign pop      = ~q_empty & de_ready & ~br_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= AWIDTH'(RESET_PC);
         resp_pc  <= AWIDTH'(RESET_PC);
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         inflight <= '0;
         discard  <= '0;
         hold_ir  <= '0;
         hold_pc  <= '0;
      end else begin
         // Head value is remembered so it stays visible after the queue drains.
         if (de_valid) begin
            hold_ir <= de_ir;
            hold_pc <= de_pc;
         end
         if (br_valid) begin
            // Every read still outstanding after this edge is stale.
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetch_pc <= br_tgt;
            resp_pc  <= br_tgt;
            inflight <= inflight - IW'(rsp_live);
            discard  <= inflight - IW'(rsp_live);
         end else begin
            if (issue)    fetch_pc <= fetch_pc + 1'b1;
            if (rsp_keep) resp_pc  <= resp_pc + 1'b1;
            if (push)     wr_ptr   <= wr_ptr + 1'b1;
            if (pop)      rd_ptr   <= rd_ptr + 1'b1;
            inflight <= inflight + IW'(issue) - IW'(rsp_live);
            if (rsp_live && discard != '0) discard <= discard - 1'b1;
         end
      end
   end

   // Queue storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_ir[wr_ptr[PW-1:0]] <= ins_rd_data;
         mem_pc[wr_ptr[PW-1:0]] <= resp_pc;
      end
   end

   rdy_protocol: assert property (@(posedge clk) disable iff (reset)
      !(ins_rd_rdy && inflight == '0));

endmodule

// File: tb/tb_cpu_fetch_queue.sv
module tb_cpu_fetch_queue;
   localparam int AW = 16, DW = 16, DEPTH = 4, MAXOUT = 2;
   localparam logic [15:0] RPC = 16'h0000;

   logic clk = 1'b0, reset = 1'b1;
   logic [AW-1:0] ins_rd_addr, br_tgt = '0;
   logic ins_rd_req, ins_rd_ack = 1'b0, ins_rd_rdy = 1'b0;
   logic [DW-1:0] ins_rd_data = '0, de_ir;
   logic [AW-1:0] de_pc;
   logic de_valid, de_ready = 1'b0, br_valid = 1'b0;

   cpu_fetch_queue #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH), .MAXOUT(MAXOUT), .RESET_PC(0)) dut (
      .clk(clk), .reset(reset), .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req),
      .ins_rd_ack(ins_rd_ack), .ins_rd_data(ins_rd_data), .ins_rd_rdy(ins_rd_rdy),
      .de_ir(de_ir), .de_pc(de_pc), .de_valid(de_valid), .de_ready(de_ready),
      .br_valid(br_valid), .br_tgt(br_tgt));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_at(input string name, input logic [15:0] q[$], input int i, input logic [15:0] exp);
      if (i >= q.size()) begin
         checks++; errors++;
         $display("FAIL %s: entry %0d missing, expected %0h", name, i, exp);
      end else chk(name, q[i], exp);
   endtask

   // Reference model: decode queue as a list of {pc, word}, plus counters.
   typedef struct packed { logic [15:0] pc; logic [15:0] ir; } ent_t;
   ent_t mq[$];
   int m_infl, m_disc;
   logic [15:0] m_fetch, m_resp, m_last_pc, m_last_ir;

   // Memory stand-in: in-order responses, at least one cycle after issue.
   logic [15:0] mem_addr[$];
   int mem_cyc[$];
   int cyc = 0;
   int ack_pct, rdy_pct, ready_pct;
   logic [15:0] iss_log[$], pop_log[$];

   function automatic logic [15:0] word_of(input logic [15:0] a);
      logic [15:0] m;
      m = a * 16'h9E37;
      return m ^ 16'h5A5A;
   endfunction

   task automatic model_reset();
      mq.delete(); m_infl = 0; m_disc = 0;
      m_fetch = RPC; m_resp = RPC; m_last_pc = '0; m_last_ir = '0;
      mem_addr.delete(); mem_cyc.delete();
   endtask

   // Entered at a falling edge; leaves at a falling edge with reset released.
   task automatic do_reset();
      reset = 1'b1;
      br_valid = 0; ins_rd_ack = 0; ins_rd_rdy = 0; de_ready = 0;
      model_reset();
      #1;
      chk("rst_req", ins_rd_req, 0);
      chk("rst_addr", ins_rd_addr, RPC);
      chk("rst_valid", de_valid, 0);
      chk("rst_ir", de_ir, 0);
      chk("rst_pc", de_pc, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // One clock: drive at the falling edge, compare, advance the model.
   task automatic step(input bit br, input logic [15:0] tgt);
      bit rdy, ack, rdy_en, byp, ev, exp_req, consumed;
      logic [15:0] data, epc, eir;
      ent_t e;
      rdy = (mem_addr.size() > 0) && (mem_cyc[0] < cyc) && ($urandom_range(99) < rdy_pct);
      data = rdy ? word_of(mem_addr[0]) : 16'($urandom);
      ack = $urandom_range(99) < ack_pct;
      rdy_en = $urandom_range(99) < ready_pct;
      br_valid = br; br_tgt = tgt; ins_rd_rdy = rdy; ins_rd_data = data;
      ins_rd_ack = ack; de_ready = rdy_en;

      exp_req = !br && (m_infl < MAXOUT) && (mq.size() + m_infl - m_disc < DEPTH);
      byp = 0;
`ifdef FETCH_BYPASS_EN
      byp = (mq.size() == 0) && (m_disc == 0) && !br && rdy;
`endif
      if (mq.size() > 0) begin ev = 1; epc = mq[0].pc; eir = mq[0].ir; end
      else if (byp)      begin ev = 1; epc = m_resp;   eir = data;     end
      else               begin ev = 0; epc = m_last_pc; eir = m_last_ir; end

      #1;
      chk("de_valid", de_valid, ev);
      chk("de_pc", de_pc, epc);
      chk("de_ir", de_ir, eir);
      chk("rd_req", ins_rd_req, exp_req);
      if (exp_req) chk("rd_addr", ins_rd_addr, m_fetch);
      if (de_valid && rdy_en && !br) pop_log.push_back(de_pc);
      if (ins_rd_req && ack) iss_log.push_back(ins_rd_addr);

      if (ev) begin m_last_pc = epc; m_last_ir = eir; end
      if (rdy) begin void'(mem_addr.pop_front()); void'(mem_cyc.pop_front()); end
      if (exp_req && ack) begin mem_addr.push_back(m_fetch); mem_cyc.push_back(cyc); end
      if (br) begin
         mq.delete();
         if (rdy) m_infl--;
         m_disc = m_infl;
         m_fetch = tgt; m_resp = tgt;
      end else begin
         consumed = 0;
         if (ev && rdy_en) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else consumed = 1;
         end
         if (rdy) begin
            m_infl--;
            if (m_disc > 0) m_disc--;
            else begin
               e = {m_resp, data};
               if (!consumed) mq.push_back(e);
               m_resp++;
            end
         end
         if (exp_req && ack) begin m_fetch++; m_infl++; end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic knobs(input int a, input int r, input int d);
      ack_pct = a; rdy_pct = r; ready_pct = d;
   endtask

   task automatic clear_logs();
      iss_log.delete(); pop_log.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge clk);
      do_reset();

      // Streaming: addresses and decoded PCs count up with no gaps.
      knobs(100, 100, 100); clear_logs();
      repeat (12) step(0, '0);
      for (int i = 0; i < 3; i++) begin
         chk_at("stream_iss", iss_log, i, 16'(i));
         chk_at("stream_pop", pop_log, i, 16'(i));
      end
      chk("stream_nogap", pop_log.size() >= 10, 1);

      // Decode stalled: exactly DEPTH issues, then the queue is full.
      do_reset(); knobs(100, 100, 0); clear_logs();
      repeat (10) step(0, '0);
      chk("full_issues", iss_log.size(), DEPTH);
      chk("full_req", ins_rd_req, 0);
      chk("full_valid", de_valid, 1);
      knobs(100, 100, 100);
      step(0, '0);
      chk("full_resume", ins_rd_req, 1);
      repeat (6) step(0, '0);

      // Redirect with two reads outstanding at 5 and 6.
      do_reset(); knobs(100, 0, 100);
      step(1, 16'h0005); clear_logs();
      repeat (3) step(0, '0);
      chk_at("br_pre_iss", iss_log, 0, 16'h0005);
      chk_at("br_pre_iss", iss_log, 1, 16'h0006);
      clear_logs();
      step(1, 16'h0040);
      knobs(100, 100, 100);
      repeat (10) step(0, '0);
      chk_at("br_iss", iss_log, 0, 16'h0040);
      chk_at("br_pop", pop_log, 0, 16'h0040);
      chk_at("br_pop", pop_log, 1, 16'h0041);

      // Redirect coinciding with a response: one more response is dropped.
      do_reset(); knobs(100, 0, 100);
      step(1, 16'h0005);
      repeat (3) step(0, '0);
      clear_logs();
      knobs(100, 100, 100);
      step(1, 16'h0080);
      repeat (10) step(0, '0);
      chk_at("brrdy_pop", pop_log, 0, 16'h0080);
      chk_at("brrdy_iss", iss_log, 0, 16'h0080);

      // Address wrap.
      do_reset(); knobs(100, 100, 100);
      step(1, 16'hFFFE); clear_logs();
      repeat (8) step(0, '0);
      chk_at("wrap_iss", iss_log, 0, 16'hFFFE);
      chk_at("wrap_iss", iss_log, 1, 16'hFFFF);
      chk_at("wrap_iss", iss_log, 2, 16'h0000);
      chk_at("wrap_pop", pop_log, 1, 16'hFFFF);
      chk_at("wrap_pop", pop_log, 2, 16'h0000);

      // Reset mid-stream with words queued and two reads in flight.
      do_reset(); knobs(100, 100, 0);
      repeat (2) step(0, '0);
      knobs(100, 0, 0);
      repeat (3) step(0, '0);
      chk("mid_valid_pre", de_valid, 1);
      do_reset();
      knobs(100, 100, 100); clear_logs();
      repeat (6) step(0, '0);
      chk_at("mid_iss", iss_log, 0, RPC);
      chk_at("mid_pop", pop_log, 0, RPC);

      // Random traffic with redirects and occasional resets.
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         logic [15:0] t;
         if (n % 50 == 0)
            knobs($urandom_range(100), $urandom_range(20, 100), $urandom_range(100));
         t = ($urandom_range(3) == 0) ? 16'hFFF0 + 16'($urandom_range(15)) : 16'($urandom);
         if ($urandom_range(999) == 0) do_reset();
         else step($urandom_range(99) < 4, t);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
